tiny_riscv_soc: RTL and testbench
=================================

Name: tiny_riscv_soc

Overview:
- Minimal simulation-oriented SoC top containing four blocks: a single-cycle RV32I core (instance u_tinyriscv), its register file (u_tinyriscv.u_regs), a writable program memory (u_rom) and a data memory (u_ram).
- Program image is preloaded by the bench via $readmemh into u_rom._rom.
- Completion is signalled by software writing 1 to RAM word 4; a compliance signature region sits in program memory.

Parameters:
- ROM_DEPTH, 4096, number of 32-bit words in u_rom._rom.
- RAM_DEPTH, 4096, number of 32-bit words in u_ram._ram.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  single system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- uart_debug_pin  input  1  debug hold. 0 = run; 1 = core stalled.

Behaviour:
- Required hierarchy for bench access:
  - u_tinyriscv.u_regs.regs[0:31], 32-bit.
  - u_rom._rom[0:ROM_DEPTH-1], 32-bit words.
  - u_ram._ram[0:RAM_DEPTH-1], 32-bit words.
- Memory map, selected by addr[31:28]:
  - 4'h0 = ROM, word index addr[31:2] modulo depth.
  - 4'h1 = RAM, word index addr[27:2].
  - Other regions: reads return 0, writes are ignored.
- ROM is writable by store instructions (the signature lives there).
- Memory timing:
  - Both memories read asynchronously (combinational).
  - Both memories write on the rising clk edge.
  - Neither memory is cleared by reset.
  - Instruction fetch and data access to ROM in the same cycle are both serviced.
- Reset (rst=0), asynchronous:
  - PC = RESET_PC.
  - All 32 registers = 0.
  - No memory writes.
  - Reset mid-run aborts the current instruction immediately.
- Core is single-cycle: each non-stalled rising edge retires exactly one instruction, updating PC, rd and memory together.
- Stall (uart_debug_pin=1): PC, register file and memories all hold; execution resumes on the first edge with the pin low.
- ISA is RV32I: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, the OP-IMM group, the OP group.
- FENCE, ECALL, EBREAK, CSR and all unknown opcodes execute as NOP (PC+4).
- x0 reads as 0; writes to x0 are discarded.
- Register file: two combinational read ports, one write port.
- Arithmetic:
  - 32-bit wrap-around.
  - SLT/SLTI signed; SLTU/SLTIU unsigned.
  - Shifts use shamt[4:0].
  - SRA/SRAI are arithmetic.
- JALR target = (rs1+imm) & ~1. JAL/JALR write PC+4 to rd, even when rd equals rs1.
- Branch/jump targets are not checked for alignment; PC[1:0] is ignored for fetch.
- Loads:
  - Byte/half lane selected by addr[1:0]/addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Misaligned LW/LH uses the word at addr[31:2] with lanes from addr[1:0]; no trap.
- Stores:
  - SB writes only the addressed byte lane; SH writes the addressed half; SW writes the full word.
  - Other bytes of the word are preserved.
- Bench convention (software contract):
  - RAM word 2 = begin_signature byte address; RAM word 3 = end_signature byte address.
  - RAM word 4 = 1 marks the end of test.
  - Signature words are read from _rom[addr>>2].

Test Plan:
- Reset/ALU: rst low 40 ns then high; program "addi x1,x0,5; addi x2,x1,-7; sub x3,x1,x2" -> after 3 edges x1=5, x2=0xFFFFFFFE, x3=7; after reset all regs 0.
- Load/store lanes and end flag: "lui x5,0x10000; addi x6,x0,-128; sb x6,17(x5); lb x7,17(x5); lbu x8,17(x5); addi x9,x0,1; sw x9,16(x5)" -> _ram[4]=1, x7=0xFFFFFF80, x8=0x80, other bytes of _ram[4] untouched before the sw.
- Control flow: BLT with x1=-1, x2=1 taken, BLTU not taken; "jal x1,+8" at PC 0x20 -> x1=0x24, PC=0x28; JALR with odd target clears bit 0.
- x0/NOP: "addi x0,x0,9" and an ECALL -> x0 stays 0, PC advances by 4 each.
- Stall and async reset: hold uart_debug_pin=1 for 5 cycles -> PC and regs frozen; drop rst mid-cycle -> PC=0 and regs=0 without waiting for a clk edge.
- Signature flow: program stores 0xDEADBEEF to ROM address 0x200, sets RAM words 2/3 to 0x200/0x204, then sets word 4 = 1 -> dumping _rom[0x80] yields deadbeef.

Source files
------------

// File: rtl/tiny_riscv_soc.sv
// tiny_riscv_soc: minimal single-cycle RV32I system for simulation.
//   Contents : u_tinyriscv (core, with register file u_regs), u_rom
//              (writable program memory), u_ram (data memory).
//   Ports    : clk            - system clock, all state on the rising edge
//              rst            - asynchronous active-low reset
//              uart_debug_pin - debug hold, 1 freezes the core
//   Map      : addr[31:28]==0 -> ROM, ==1 -> RAM, anything else reads 0
//              and drops writes. Memories read combinationally, write on
//              the clock edge and are never cleared by reset.

// Register file: two combinational read ports, one write port.
//   Ports: rs1/rs2 address+data, we/rd_addr/rd_data write port.
module tinyriscv_regs (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        we,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data
);
  localparam int NREGS = 32;
  logic [31:0] regs [0:NREGS-1];

  // Register array: cleared asynchronously; x0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= 32'h0000_0000;
    end else if (we && (rd_addr != 5'd0)) begin
      regs[rd_addr] <= rd_data;
    end
  end

  // Read ports with x0 hard-wired to zero
  always_comb begin
    if (rs1_addr == 5'd0) rs1_data = 32'h0000_0000;
    else                  rs1_data = regs[rs1_addr];
    if (rs2_addr == 5'd0) rs2_data = 32'h0000_0000;
    else                  rs2_data = regs[rs2_addr];
  end
endmodule

// Program memory: fetch port plus one byte-enabled data port.
//   Ports: fetch_idx/fetch_data, data_idx/data_rdata/data_be/data_wdata.
module tinyriscv_rom #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] fetch_idx,
  output logic [31:0]   fetch_data,
  input  logic [AW-1:0] data_idx,
  output logic [31:0]   data_rdata,
  input  logic [3:0]    data_be,
  input  logic [31:0]   data_wdata
);
  logic [31:0] _rom [0:DEPTH-1];

  // Byte-lane writes; untouched lanes keep their contents
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (data_be[b]) _rom[data_idx][8*b +: 8] <= data_wdata[8*b +: 8];
    end
  end

  assign fetch_data = _rom[fetch_idx];
  assign data_rdata = _rom[data_idx];
endmodule

// Data memory: one byte-enabled read/write port.
//   Ports: idx/rdata/be/wdata.
module tinyriscv_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] idx,
  output logic [31:0]   rdata,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata
);
  logic [31:0] _ram [0:DEPTH-1];

  // Byte-lane writes; untouched lanes keep their contents
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) _ram[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = _ram[idx];
endmodule

// Single-cycle RV32I core: one instruction retires per non-stalled edge.
//   Ports: imem_addr/imem_rdata fetch, dmem_addr/dmem_rdata/dmem_wdata/
//          dmem_be data bus (be is zero unless a store retires this edge).
module tinyriscv #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] dmem_addr,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [31:0] pc_q, pc_d, next_pc, instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_data, rs2_data, rd_data, load_val, byte_word, half_word;
  logic [3:0]  store_be;
  logic        rd_we;

  // alt selects SUB / SRA / SRAI within the shared funct3 decode
  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'b000:  r = alt ? (a - b) : (a + b);
      3'b001:  r = a << b[4:0];
      3'b010:  r = {31'd0, ($signed(a) < $signed(b))};
      3'b011:  r = {31'd0, (a < b)};
      3'b100:  r = a ^ b;
      3'b101:  begin
                 if (alt) r = $signed(a) >>> b[4:0];
                 else     r = a >> b[4:0];
               end
      3'b110:  r = a | b;
      3'b111:  r = a & b;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] b);
    logic t;
    case (f3)
      3'b000:  t = (a == b);
      3'b001:  t = (a != b);
      3'b100:  t = ($signed(a) < $signed(b));
      3'b101:  t = ($signed(a) >= $signed(b));
      3'b110:  t = (a < b);
      3'b111:  t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  assign imem_addr = pc_q;
  assign instr     = imem_rdata;
  assign opcode    = instr[6:0];
  assign rd        = instr[11:7];
  assign funct3    = instr[14:12];
  assign rs1       = instr[19:15];
  assign rs2       = instr[24:20];
  assign imm_i     = {{20{instr[31]}}, instr[31:20]};
  assign imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u     = {instr[31:12], 12'h000};
  assign imm_j     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  tinyriscv_regs u_regs (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (rd_we && !stall),
    .rd_addr  (rd),
    .rd_data  (rd_data)
  );

  // Data address, load lane extraction and store lane generation
  always_comb begin
    if (opcode == OP_STORE) dmem_addr = rs1_data + imm_s;
    else                    dmem_addr = rs1_data + imm_i;
    byte_word = dmem_rdata >> {dmem_addr[1:0], 3'b000};
    half_word = dmem_rdata >> {dmem_addr[1], 4'b0000};
    case (funct3)
      3'b000:  load_val = {{24{byte_word[7]}}, byte_word[7:0]};
      3'b001:  load_val = {{16{half_word[15]}}, half_word[15:0]};
      3'b100:  load_val = {24'h000000, byte_word[7:0]};
      3'b101:  load_val = {16'h0000, half_word[15:0]};
      default: load_val = dmem_rdata;
    endcase
    case (funct3[1:0])
      2'b00: begin
        store_be   = 4'b0001 << dmem_addr[1:0];
        dmem_wdata = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        store_be   = dmem_addr[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{rs2_data[15:0]}};
      end
      2'b10: begin
        store_be   = 4'b1111;
        dmem_wdata = rs2_data;
      end
      default: begin
        store_be   = 4'b0000;
        dmem_wdata = rs2_data;
      end
    endcase
  end

  // Instruction execute: next PC, write-back value and store enable
  always_comb begin
    next_pc = pc_q + 32'd4;
    rd_we   = 1'b0;
    rd_data = 32'h0000_0000;
    dmem_be = 4'b0000;
    case (opcode)
      OP_LUI:    begin rd_we = 1'b1; rd_data = imm_u;         end
      OP_AUIPC:  begin rd_we = 1'b1; rd_data = pc_q + imm_u;  end
      OP_JAL: begin
        rd_we   = 1'b1;
        rd_data = pc_q + 32'd4;
        next_pc = pc_q + imm_j;
      end
      OP_JALR: begin
        rd_we   = 1'b1;
        rd_data = pc_q + 32'd4;
        next_pc = (rs1_data + imm_i) & 32'hFFFF_FFFE;
      end
      OP_BRANCH: begin
        if (branch_taken(funct3, rs1_data, rs2_data)) next_pc = pc_q + imm_b;
        else                                          next_pc = pc_q + 32'd4;
      end
      OP_LOAD:   begin rd_we = 1'b1; rd_data = load_val; end
      // Writes are suppressed while stalled or held in reset
      OP_STORE: begin
        if (!stall && rst_n) dmem_be = store_be;
        else                 dmem_be = 4'b0000;
      end
      OP_IMM: begin
        rd_we   = 1'b1;
        rd_data = alu(funct3, (funct3 == 3'b101) && instr[30], rs1_data, imm_i);
      end
      OP_OP: begin
        rd_we   = 1'b1;
        rd_data = alu(funct3, instr[30], rs1_data, rs2_data);
      end
      // FENCE / SYSTEM / unknown opcodes fall through as NOP
      default:   next_pc = pc_q + 32'd4;
    endcase
    if (stall) pc_d = pc_q;
    else       pc_d = next_pc;
  end

  // Program counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end
endmodule

// SoC top: core, program memory and data memory with address decode.
module tiny_riscv_soc #(
  parameter int          ROM_DEPTH = 4096,
  parameter int          RAM_DEPTH = 4096,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  input logic uart_debug_pin
);
  localparam int ROM_AW = $clog2(ROM_DEPTH);
  localparam int RAM_AW = $clog2(RAM_DEPTH);

  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_rdata, dmem_wdata;
  logic [31:0] rom_rdata, ram_rdata;
  logic [3:0]  dmem_be, rom_be, ram_be;
  logic        unused_addr_bits;

  // Address bits that fall outside the decoded fields
  assign unused_addr_bits = ^{imem_addr[31:ROM_AW+2], imem_addr[1:0], dmem_addr[1:0],
                              dmem_addr[27:ROM_AW+2], dmem_addr[27:RAM_AW+2]};

  tinyriscv #(.RESET_PC(RESET_PC)) u_tinyriscv (
    .clk        (clk),
    .rst_n      (rst),
    .stall      (uart_debug_pin),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dmem_addr  (dmem_addr),
    .dmem_rdata (dmem_rdata),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be)
  );

  tinyriscv_rom #(.DEPTH(ROM_DEPTH)) u_rom (
    .clk        (clk),
    .fetch_idx  (imem_addr[ROM_AW+1:2]),
    .fetch_data (imem_rdata),
    .data_idx   (dmem_addr[ROM_AW+1:2]),
    .data_rdata (rom_rdata),
    .data_be    (rom_be),
    .data_wdata (dmem_wdata)
  );

  tinyriscv_ram #(.DEPTH(RAM_DEPTH)) u_ram (
    .clk   (clk),
    .idx   (dmem_addr[RAM_AW+1:2]),
    .rdata (ram_rdata),
    .be    (ram_be),
    .wdata (dmem_wdata)
  );

  // Region decode on addr[31:28]; unmapped regions read 0, drop writes
  always_comb begin
    if (dmem_addr[31:28] == 4'h0) begin
      rom_be     = dmem_be;
      ram_be     = 4'b0000;
      dmem_rdata = rom_rdata;
    end else if (dmem_addr[31:28] == 4'h1) begin
      rom_be     = 4'b0000;
      ram_be     = dmem_be;
      dmem_rdata = ram_rdata;
    end else begin
      rom_be     = 4'b0000;
      ram_be     = 4'b0000;
      dmem_rdata = 32'h0000_0000;
    end
  end
endmodule

// File: tb/tb_tiny_riscv_soc.sv
// Self-checking bench for tiny_riscv_soc: directed programs from the test
// plan followed by randomized ALU programs checked against an ISA-level
// arithmetic model.
module tb_tiny_riscv_soc;
  logic clk;
  logic rst;
  logic uart_debug_pin;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [31:0] prog [$];

  tiny_riscv_soc dut (
    .clk            (clk),
    .rst            (rst),
    .uart_debug_pin (uart_debug_pin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'h37};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [31:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'h13);
  endfunction

  // ISA meaning of the ten OP mnemonics, indexed 0..9:
  // add sub sll slt sltu xor srl sra or and
  function automatic logic [31:0] model(input int k, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (k)
      0: return a + b;
      1: return a - b;
      2: return a << sh;
      3: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4: return (longint'({32'd0, a}) < longint'({32'd0, b})) ? 32'd1 : 32'd0;
      5: return a ^ b;
      6: return a >> sh;
      7: return 32'(int'(a) >>> sh);
      8: return a | b;
      default: return a & b;
    endcase
  endfunction
  function automatic logic [2:0] f3_of(input int k);
    case (k)
      0, 1: return 3'd0;
      2: return 3'd1;
      3: return 3'd2;
      4: return 3'd3;
      5: return 3'd4;
      6, 7: return 3'd5;
      8: return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [31:0] xr(input int i);
    return dut.u_tinyriscv.u_regs.regs[i];
  endfunction
  function automatic logic [31:0] pc();
    return dut.u_tinyriscv.pc_q;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset, fill the low program area with NOPs, load prog, release
  task automatic reset_and_load();
    rst = 1'b0;
    uart_debug_pin = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) dut.u_rom._rom[i] = NOP;
    for (int i = 0; i < prog.size(); i++) dut.u_rom._rom[i] = prog[i];
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] a, b, bval, tmp, ua, sig_begin;
    logic [11:0] field;
    logic [4:0]  sh;
    int kr, ki;

    // ---------------- Reset / ALU ----------------
    rst = 1'b1;
    uart_debug_pin = 1'b0;
    #2 rst = 1'b0;
    prog = {addi(1, 0, 5), addi(2, 1, -7), enc_r(7'h20, 2, 1, 3'd0, 3, 7'h33)};
    for (int i = 0; i < 64; i++) dut.u_rom._rom[i] = NOP;
    for (int i = 0; i < prog.size(); i++) dut.u_rom._rom[i] = prog[i];
    #20;
    check("reset_pc", pc(), 32'h0);
    for (int i = 0; i < 32; i++) check($sformatf("reset_x%0d", i), xr(i), 32'h0);
    #20 rst = 1'b1;
    step(3);
    check("alu_x1", xr(1), 32'd5);
    check("alu_x2", xr(2), 32'hFFFF_FFFE);
    check("alu_x3", xr(3), 32'd7);
    check("alu_pc", pc(), 32'h0C);

    // ---------------- Load/store lanes ----------------
    prog = {enc_u(20'h10000, 5), addi(6, 0, -128),
            enc_s(17, 6, 5, 3'b000),
            enc_i(17, 5, 3'b000, 7, 7'h03), enc_i(17, 5, 3'b100, 8, 7'h03),
            enc_s(18, 6, 5, 3'b001), enc_i(18, 5, 3'b001, 10, 7'h03),
            addi(9, 0, 1), enc_s(16, 9, 5, 3'b010)};
    dut.u_ram._ram[4] = 32'h1122_3344;
    reset_and_load();
    step(3);
    check("sb_lane", dut.u_ram._ram[4], 32'h1122_8044);
    step(3);
    check("lb_sext", xr(7), 32'hFFFF_FF80);
    check("lbu_zext", xr(8), 32'h0000_0080);
    check("sh_lane", dut.u_ram._ram[4], 32'hFF80_8044);
    step(1);
    check("lh_sext", xr(10), 32'hFFFF_FF80);
    step(2);
    check("sw_flag", dut.u_ram._ram[4], 32'd1);

    // ---------------- Control flow ----------------
    prog = {addi(1, 0, -1), addi(2, 0, 1), enc_b(8, 2, 1, 3'b100), addi(10, 0, 1),
            enc_b(8, 2, 1, 3'b110), addi(11, 0, 2), NOP, NOP,
            enc_j(8, 1), addi(12, 0, 3), addi(13, 0, 32'h41),
            enc_i(0, 13, 3'b000, 13, 7'h67), NOP, NOP, NOP, NOP, addi(15, 0, 7)};
    reset_and_load();
    step(3);
    check("blt_taken_pc", pc(), 32'h10);
    step(2);
    check("bltu_fall_pc", pc(), 32'h18);
    check("bltu_fall_x11", xr(11), 32'd2);
    check("blt_skip_x10", xr(10), 32'd0);
    step(3);
    check("jal_pc", pc(), 32'h28);
    check("jal_link", xr(1), 32'h24);
    step(2);
    check("jalr_pc", pc(), 32'h40);
    check("jalr_link", xr(13), 32'h30);
    step(1);
    check("jalr_target_x15", xr(15), 32'd7);
    check("jal_skip_x12", xr(12), 32'd0);

    // ---------------- x0 / NOP ----------------
    prog = {addi(0, 0, 9), 32'h0000_0073, 32'h0000_000F};
    reset_and_load();
    step(1);
    check("x0_pc", pc(), 32'h4);
    check("x0_zero", xr(0), 32'h0);
    step(1);
    check("ecall_pc", pc(), 32'h8);
    step(1);
    check("fence_pc", pc(), 32'hC);

    // ---------------- Stall and async reset ----------------
    prog = {addi(1, 0, 1), addi(1, 1, 1), addi(1, 1, 1), addi(1, 1, 1), addi(1, 1, 1)};
    reset_and_load();
    step(2);
    check("pre_stall_x1", xr(1), 32'd2);
    uart_debug_pin = 1'b1;
    step(5);
    check("stall_pc", pc(), 32'h8);
    check("stall_x1", xr(1), 32'd2);
    uart_debug_pin = 1'b0;
    step(1);
    check("resume_x1", xr(1), 32'd3);
    check("resume_pc", pc(), 32'hC);
    #3 rst = 1'b0;
    #1;
    check("async_rst_pc", pc(), 32'h0);
    check("async_rst_x1", xr(1), 32'h0);

    // ---------------- Signature flow ----------------
    prog = {enc_u(20'hDEADC, 1), addi(1, 1, -273), addi(2, 0, 32'h200),
            enc_s(0, 1, 2, 3'b010), enc_u(20'h10000, 5),
            addi(3, 0, 32'h200), enc_s(8, 3, 5, 3'b010),
            addi(3, 0, 32'h204), enc_s(12, 3, 5, 3'b010),
            addi(4, 0, 1), enc_s(16, 4, 5, 3'b010), enc_j(0, 0)};
    dut.u_ram._ram[2] = 32'h0;
    dut.u_ram._ram[3] = 32'h0;
    dut.u_ram._ram[4] = 32'h0;
    dut.u_rom._rom[32'h80] = 32'h0;
    reset_and_load();
    for (int c = 0; c < 100; c++) begin
      step(1);
      if (dut.u_ram._ram[4] == 32'd1) break;
    end
    check("end_flag", dut.u_ram._ram[4], 32'd1);
    check("sig_begin", dut.u_ram._ram[2], 32'h200);
    check("sig_end", dut.u_ram._ram[3], 32'h204);
    sig_begin = dut.u_ram._ram[2] >> 2;
    check("sig_word", dut.u_rom._rom[sig_begin[11:0]], 32'hDEAD_BEEF);

    // ---------------- Randomized ALU programs ----------------
    for (int it = 0; it < 30; it++) begin
      a  = $urandom;
      b  = $urandom;
      kr = $urandom_range(0, 9);
      do ki = $urandom_range(0, 9); while (ki == 1);
      tmp = $urandom;
      if (ki == 2 || ki == 6 || ki == 7) begin
        sh    = tmp[4:0];
        field = {(ki == 7) ? 7'h20 : 7'h00, sh};
        bval  = {27'd0, sh};
      end else begin
        field = tmp[11:0];
        bval  = {{20{field[11]}}, field};
      end
      ua = a + 32'h800;
      tmp = b + 32'h800;
      prog = {enc_u(ua[31:12], 1), addi(1, 1, {20'd0, a[11:0]}),
              enc_u(tmp[31:12], 2), addi(2, 2, {20'd0, b[11:0]}),
              enc_r((kr == 1 || kr == 7) ? 7'h20 : 7'h00, 2, 1, f3_of(kr), 3, 7'h33),
              enc_i({20'd0, field}, 1, f3_of(ki), 4, 7'h13)};
      reset_and_load();
      step(6);
      check($sformatf("rnd%0d_a", it), xr(1), a);
      check($sformatf("rnd%0d_op%0d", it, kr), xr(3), model(kr, a, b));
      check($sformatf("rnd%0d_opimm%0d", it, ki), xr(4), model(ki, a, bval));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
